// File: rtl/player_motion_controller.sv
// player_motion_controller: per-frame player state updater.
// Applies a rate-limited turn and a signed direction-vector step, and validates
// each candidate position against the map through a cell-lookup handshake.
// Build option: define PLAYER_SLIDE_EN for per-axis checks (wall sliding);
// when undefined, a single combined lookup accepts both axes or neither.
module player_motion_controller #(
  parameter int X_W       = 14,
  parameter int Y_W       = 13,
  parameter int ANG_W     = 8,
  parameter int TURN_STEP = 10,
  parameter int TICK_W    = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             turn_right,
  input  logic             turn_left,
  input  logic             move_fwd,
  input  logic             move_back,
  input  logic [X_W-1:0]   cur_pos_x,
  input  logic [Y_W-1:0]   cur_pos_y,
  input  logic [ANG_W-1:0] cur_angle,
  input  logic [X_W:0]     dir_x,
  input  logic [Y_W:0]     dir_y,
  output logic             query_valid,
  output logic [X_W-1:0]   query_x,
  output logic [Y_W-1:0]   query_y,
  input  logic             cell_valid,
  input  logic [2:0]       cell_type,
  output logic [X_W-1:0]   next_pos_x,
  output logic [Y_W-1:0]   next_pos_y,
  output logic [ANG_W-1:0] next_angle
);

  localparam logic [ANG_W-1:0] TURN_INC = ANG_W'(TURN_STEP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TURN,
    S_QUERY_X,
    S_WAIT_X,
    S_QUERY_Y,
    S_WAIT_Y,
    S_COMMIT,
    S_DONE
  } state_t;

  state_t            state;
  logic [TICK_W-1:0] tick;

  logic [ANG_W-1:0]  ang_w;
  logic [X_W-1:0]    cand_x_w;
  logic [Y_W-1:0]    cand_y_w;
  logic              x_in_w;
  logic              y_in_w;
  logic [X_W-1:0]    acc_x_w;
  logic [Y_W-1:0]    acc_y_w;

  logic [X_W+1:0]    step_x;
  logic [Y_W+1:0]    step_y;
  logic [X_W+1:0]    cand_x_c;
  logic [Y_W+1:0]    cand_y_c;
  logic [ANG_W-1:0]  turned_c;
  logic              move_c;

  // Candidate position and turned angle from the live inputs, captured in TURN.
  // Candidates carry two extra bits so any value outside [0, 2^W) shows up as
  // a nonzero top pair, covering both negative results and overflow.
  always_comb begin
    step_x   = {dir_x[X_W], dir_x};
    step_y   = {dir_y[Y_W], dir_y};
    cand_x_c = {2'b00, cur_pos_x} + step_x;
    cand_y_c = {2'b00, cur_pos_y} + step_y;
    if (move_back) begin
      cand_x_c = {2'b00, cur_pos_x} - step_x;
      cand_y_c = {2'b00, cur_pos_y} - step_y;
    end
    move_c   = move_fwd ^ move_back;
    turned_c = cur_angle;
    if (turn_right && !turn_left) begin
      turned_c = cur_angle + TURN_INC;
    end else if (turn_left && !turn_right) begin
      turned_c = cur_angle - TURN_INC;
    end
  end

  // Update sequencer: launch gating, lookup handshake and commit.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      tick        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      query_valid <= 1'b0;
      query_x     <= '0;
      query_y     <= '0;
      next_pos_x  <= cur_pos_x;
      next_pos_y  <= cur_pos_y;
      next_angle  <= cur_angle;
      ang_w       <= '0;
      cand_x_w    <= '0;
      cand_y_w    <= '0;
      x_in_w      <= 1'b0;
      y_in_w      <= 1'b0;
      acc_x_w     <= '0;
      acc_y_w     <= '0;
    end else begin
      tick <= tick + 1'b1;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && (tick == '0)) begin
            state <= S_TURN;
            busy  <= 1'b1;
          end
        end
        S_TURN: begin
          ang_w    <= turned_c;
          cand_x_w <= cand_x_c[X_W-1:0];
          cand_y_w <= cand_y_c[Y_W-1:0];
          x_in_w   <= (cand_x_c[X_W+1:X_W] == 2'b00);
          y_in_w   <= (cand_y_c[Y_W+1:Y_W] == 2'b00);
          acc_x_w  <= cur_pos_x;
          acc_y_w  <= cur_pos_y;
          state    <= move_c ? S_QUERY_X : S_COMMIT;
        end
`ifdef PLAYER_SLIDE_EN
        S_QUERY_X: begin
          if (x_in_w) begin
            query_valid <= 1'b1;
            query_x     <= cand_x_w;
            query_y     <= acc_y_w;
            state       <= S_WAIT_X;
          end else begin
            state <= S_QUERY_Y;
          end
        end
        S_WAIT_X: begin
          if (cell_valid) begin
            query_valid <= 1'b0;
            if (cell_type == 3'd0) begin
              acc_x_w <= cand_x_w;
            end
            state <= S_QUERY_Y;
          end
        end
`else
        S_QUERY_X: begin
          if (x_in_w && y_in_w) begin
            query_valid <= 1'b1;
            query_x     <= cand_x_w;
            query_y     <= cand_y_w;
            state       <= S_WAIT_X;
          end else begin
            state <= S_COMMIT;
          end
        end
        S_WAIT_X: begin
          if (cell_valid) begin
            query_valid <= 1'b0;
            if (cell_type == 3'd0) begin
              acc_x_w <= cand_x_w;
              acc_y_w <= cand_y_w;
            end
            state <= S_COMMIT;
          end
        end
`endif
        S_QUERY_Y: begin
          if (y_in_w) begin
            query_valid <= 1'b1;
            query_x     <= acc_x_w;
            query_y     <= cand_y_w;
            state       <= S_WAIT_Y;
          end else begin
            state <= S_COMMIT;
          end
        end
        S_WAIT_Y: begin
          if (cell_valid) begin
            query_valid <= 1'b0;
            if (cell_type == 3'd0) begin
              acc_y_w <= cand_y_w;
            end
            state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          next_angle <= ang_w;
          next_pos_x <= acc_x_w;
          next_pos_y <= acc_y_w;
          done       <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_motion_controller.sv
// Bench for player_motion_controller: directed scenarios plus randomized updates
// checked against an arithmetic reference model and a behavioural map responder.
module tb_player_motion_controller;

  localparam int X_W       = 14;
  localparam int Y_W       = 13;
  localparam int ANG_W     = 8;
  localparam int TURN_STEP = 10;
  localparam int TICK_W    = 4;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             busy, done;
  logic             turn_right = 1'b0, turn_left = 1'b0, move_fwd = 1'b0, move_back = 1'b0;
  logic [X_W-1:0]   cur_pos_x = '0;
  logic [Y_W-1:0]   cur_pos_y = '0;
  logic [ANG_W-1:0] cur_angle = '0;
  logic [X_W:0]     dir_x = '0;
  logic [Y_W:0]     dir_y = '0;
  logic             query_valid;
  logic [X_W-1:0]   query_x;
  logic [Y_W-1:0]   query_y;
  logic             cell_valid = 1'b0;
  logic [2:0]       cell_type = 3'd0;
  logic [X_W-1:0]   next_pos_x;
  logic [Y_W-1:0]   next_pos_y;
  logic [ANG_W-1:0] next_angle;

  int checks = 0;
  int errors = 0;

  player_motion_controller #(
    .X_W(X_W), .Y_W(Y_W), .ANG_W(ANG_W), .TURN_STEP(TURN_STEP), .TICK_W(TICK_W)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .turn_right(turn_right), .turn_left(turn_left), .move_fwd(move_fwd), .move_back(move_back),
    .cur_pos_x(cur_pos_x), .cur_pos_y(cur_pos_y), .cur_angle(cur_angle),
    .dir_x(dir_x), .dir_y(dir_y),
    .query_valid(query_valid), .query_x(query_x), .query_y(query_y),
    .cell_valid(cell_valid), .cell_type(cell_type),
    .next_pos_x(next_pos_x), .next_pos_y(next_pos_y), .next_angle(next_angle)
  );

  always #5 clock = ~clock;

  // Map model: explicit blocked list, or a hash-defined map for random runs.
  bit use_hash = 1'b0;
  int blk_x[$];
  int blk_y[$];

  function automatic bit is_blocked(int x, int y);
    if (use_hash) return ((x * 7 + y * 13) % 3) == 0;
    foreach (blk_x[i]) if (blk_x[i] == x && blk_y[i] == y) return 1'b1;
    return 1'b0;
  endfunction

  // Map responder: answers each query after 1..3 cycles, logs every query,
  // and throws in stray strobes while no query is outstanding.
  bit hold_resp = 1'b0;
  bit pend = 1'b0;
  int lat = 0;
  int pend_x, pend_y;
  int qxs[$];
  int qys[$];

  always @(negedge clock) begin
    cell_valid = 1'b0;
    cell_type  = 3'($urandom);
    if (reset) begin
      pend = 1'b0;
    end else begin
      if (query_valid && !pend) begin
        pend   = 1'b1;
        pend_x = int'(query_x);
        pend_y = int'(query_y);
        qxs.push_back(pend_x);
        qys.push_back(pend_y);
        lat    = int'($urandom_range(0, 2));
      end
      if (pend && !hold_resp) begin
        if (lat == 0) begin
          cell_valid = 1'b1;
          cell_type  = is_blocked(pend_x, pend_y) ? 3'($urandom_range(1, 7)) : 3'd0;
          pend       = 1'b0;
        end else begin
          lat = lat - 1;
        end
      end else if (!pend && !query_valid && $urandom_range(0, 7) == 0) begin
        cell_valid = 1'b1;
        cell_type  = 3'd0;
      end
    end
  end

  // Reference model: expected commit values and expected query sequence.
  int exp_qx[$];
  int exp_qy[$];

  task automatic model(input int cx, cy, ca, dx, dy, input bit r, l, f, b,
                       output int ex, ey, ea);
    int t, tx, ty, sg;
    bit inx, iny;
    exp_qx.delete();
    exp_qy.delete();
    t = 0;
    if (r && !l) t = TURN_STEP;
    else if (l && !r) t = -TURN_STEP;
    ea = ((ca + t) % (1 << ANG_W) + (1 << ANG_W)) % (1 << ANG_W);
    ex = cx;
    ey = cy;
    if (f != b) begin
      sg  = f ? 1 : -1;
      tx  = cx + sg * dx;
      ty  = cy + sg * dy;
      inx = (tx >= 0) && (tx < (1 << X_W));
      iny = (ty >= 0) && (ty < (1 << Y_W));
`ifdef PLAYER_SLIDE_EN
      if (inx) begin
        exp_qx.push_back(tx); exp_qy.push_back(cy);
        if (!is_blocked(tx, cy)) ex = tx;
      end
      if (iny) begin
        exp_qx.push_back(ex); exp_qy.push_back(ty);
        if (!is_blocked(ex, ty)) ey = ty;
      end
`else
      if (inx && iny) begin
        exp_qx.push_back(tx); exp_qy.push_back(ty);
        if (!is_blocked(tx, ty)) begin
          ex = tx;
          ey = ty;
        end
      end
`endif
    end
  endtask

  // Drive one update request and hold start until done (bounded).
  task automatic run_update(input int cx, cy, ca, dx, dy, input bit r, l, f, b,
                            output int ox, oy, oa, output bit ok);
    @(negedge clock);
    cur_pos_x  = cx[X_W-1:0];
    cur_pos_y  = cy[Y_W-1:0];
    cur_angle  = ca[ANG_W-1:0];
    dir_x      = dx[X_W:0];
    dir_y      = dy[Y_W:0];
    turn_right = r; turn_left = l; move_fwd = f; move_back = b;
    qxs.delete();
    qys.delete();
    start = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock);
      if (done === 1'b1) ok = 1'b1;
    end
    start = 1'b0;
    ox = int'(next_pos_x);
    oy = int'(next_pos_y);
    oa = int'(next_angle);
  endtask

  task automatic test_reset();
    cur_pos_x = 14'd1234; cur_pos_y = 13'd567; cur_angle = 8'd89;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (query_valid !== 1'b0) begin errors++; $display("FAIL reset_qv got %b want 0", query_valid); end
    checks++; if (query_x !== '0 || query_y !== '0) begin errors++; $display("FAIL reset_query got (%0d,%0d) want (0,0)", query_x, query_y); end
    checks++; if (next_pos_x !== 14'd1234 || next_pos_y !== 13'd567) begin errors++; $display("FAIL reset_next_pos got (%0d,%0d) want (1234,567)", next_pos_x, next_pos_y); end
    checks++; if (next_angle !== 8'd89) begin errors++; $display("FAIL reset_next_angle got %0d want 89", next_angle); end
    reset = 1'b0;
  endtask

  task automatic test_turn_wrap();
    bit seen_b, seen_d;
    int lat_c;
    @(negedge clock);
    cur_pos_x = 14'd500; cur_pos_y = 13'd300; cur_angle = 8'd250;
    dir_x = '0; dir_y = '0;
    turn_right = 1'b1; turn_left = 1'b0; move_fwd = 1'b0; move_back = 1'b0;
    qxs.delete(); qys.delete();
    start = 1'b1;
    seen_b = 1'b0; seen_d = 1'b0; lat_c = 0;
    for (int i = 0; i < 40 && !seen_b; i++) begin
      @(negedge clock);
      if (busy === 1'b1) seen_b = 1'b1;
    end
    for (int i = 1; i <= 20 && seen_b && !seen_d; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin seen_d = 1'b1; lat_c = i + 1; end
    end
    start = 1'b0;
    checks++; if (!seen_d || lat_c != 3) begin errors++; $display("FAIL turn_latency got %0d want 3 (0 = timeout)", lat_c); end
    checks++; if (next_angle !== 8'd4) begin errors++; $display("FAIL turn_wrap_angle got %0d want 4", next_angle); end
    checks++; if (next_pos_x !== 14'd500 || next_pos_y !== 13'd300) begin errors++; $display("FAIL turn_pos got (%0d,%0d) want (500,300)", next_pos_x, next_pos_y); end
    checks++; if (qxs.size() != 0) begin errors++; $display("FAIL turn_no_query got %0d queries want 0", qxs.size()); end
    @(negedge clock);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b want 0", done); end
    turn_right = 1'b0;
  endtask

  task automatic test_move_free();
    int ox, oy, oa;
    bit ok;
    use_hash = 1'b0; blk_x.delete(); blk_y.delete();
    run_update(100, 50, 20, 3, -2, 1'b0, 1'b0, 1'b1, 1'b0, ox, oy, oa, ok);
    checks++; if (!ok) begin errors++; $display("FAIL move_free_timeout got no done want done"); end
    checks++; if (ox != 103 || oy != 48 || oa != 20) begin errors++; $display("FAIL move_free got (%0d,%0d,%0d) want (103,48,20)", ox, oy, oa); end
`ifdef PLAYER_SLIDE_EN
    checks++; if (qxs.size() != 2 || qxs[0] != 103 || qys[0] != 50 || qxs[1] != 103 || qys[1] != 48) begin
      errors++; $display("FAIL move_free_queries got %0d queries first (%0d,%0d) want (103,50),(103,48)", qxs.size(), qxs.size() > 0 ? qxs[0] : -1, qys.size() > 0 ? qys[0] : -1);
    end
`else
    checks++; if (qxs.size() != 1 || qxs[0] != 103 || qys[0] != 48) begin
      errors++; $display("FAIL move_free_queries got %0d queries first (%0d,%0d) want (103,48)", qxs.size(), qxs.size() > 0 ? qxs[0] : -1, qys.size() > 0 ? qys[0] : -1);
    end
`endif
  endtask

  task automatic test_slide();
    int ox, oy, oa;
    bit ok;
    use_hash = 1'b0; blk_x.delete(); blk_y.delete();
    blk_x.push_back(103); blk_y.push_back(50);
    blk_x.push_back(103); blk_y.push_back(48);
    run_update(100, 50, 7, 3, -2, 1'b0, 1'b1, 1'b1, 1'b0, ox, oy, oa, ok);
    checks++; if (!ok) begin errors++; $display("FAIL slide_timeout got no done want done"); end
`ifdef PLAYER_SLIDE_EN
    checks++; if (ox != 100 || oy != 48 || oa != 253) begin errors++; $display("FAIL slide got (%0d,%0d,%0d) want (100,48,253)", ox, oy, oa); end
    checks++; if (qxs.size() != 2 || qxs[1] != 100 || qys[1] != 48) begin errors++; $display("FAIL slide_queries got %0d queries want 2 ending (100,48)", qxs.size()); end
`else
    checks++; if (ox != 100 || oy != 50 || oa != 253) begin errors++; $display("FAIL slide got (%0d,%0d,%0d) want (100,50,253)", ox, oy, oa); end
    checks++; if (qxs.size() != 1) begin errors++; $display("FAIL slide_queries got %0d queries want 1", qxs.size()); end
`endif
    blk_x.delete(); blk_y.delete();
  endtask

  task automatic test_x_oob();
    int ox, oy, oa;
    bit ok;
    use_hash = 1'b0; blk_x.delete(); blk_y.delete();
    run_update(1, 50, 0, -3, -2, 1'b0, 1'b0, 1'b1, 1'b0, ox, oy, oa, ok);
    checks++; if (!ok) begin errors++; $display("FAIL x_oob_timeout got no done want done"); end
`ifdef PLAYER_SLIDE_EN
    checks++; if (ox != 1 || oy != 48) begin errors++; $display("FAIL x_oob got (%0d,%0d) want (1,48)", ox, oy); end
    checks++; if (qxs.size() != 1 || qxs[0] != 1 || qys[0] != 48) begin errors++; $display("FAIL x_oob_queries got %0d queries want 1 at (1,48)", qxs.size()); end
`else
    checks++; if (ox != 1 || oy != 50) begin errors++; $display("FAIL x_oob got (%0d,%0d) want (1,50)", ox, oy); end
    checks++; if (qxs.size() != 0) begin errors++; $display("FAIL x_oob_queries got %0d queries want 0", qxs.size()); end
`endif
  endtask

  task automatic test_reset_in_wait();
    bit seen_q;
    int dones;
    @(negedge clock);
    hold_resp = 1'b1;
    cur_pos_x = 14'd100; cur_pos_y = 13'd50; cur_angle = 8'd33;
    dir_x = 15'd3; dir_y = 14'd2;
    turn_right = 1'b0; turn_left = 1'b0; move_fwd = 1'b1; move_back = 1'b0;
    start = 1'b1;
    seen_q = 1'b0;
    for (int i = 0; i < 60 && !seen_q; i++) begin
      @(negedge clock);
      if (query_valid === 1'b1) seen_q = 1'b1;
    end
    checks++; if (!seen_q) begin errors++; $display("FAIL rst_wait_query got no query want query"); end
    @(negedge clock);
    start = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    checks++; if (query_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rst_wait_abort got qv=%b busy=%b done=%b want 0,0,0", query_valid, busy, done);
    end
    checks++; if (next_pos_x !== 14'd100 || next_pos_y !== 13'd50 || next_angle !== 8'd33) begin
      errors++; $display("FAIL rst_wait_next got (%0d,%0d,%0d) want (100,50,33)", next_pos_x, next_pos_y, next_angle);
    end
    reset = 1'b0;
    hold_resp = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (done === 1'b1) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL rst_wait_no_done got %0d done pulses want 0", dones); end
    move_fwd = 1'b0;
  endtask

  task automatic test_tick_rate();
    bit first;
    int cnt, last, badgap;
    @(negedge clock);
    cur_pos_x = 14'd10; cur_pos_y = 13'd10; cur_angle = 8'd5;
    turn_right = 1'b0; turn_left = 1'b1; move_fwd = 1'b0; move_back = 1'b0;
    start = 1'b1;
    first = 1'b0;
    for (int i = 0; i < 40 && !first; i++) begin
      @(negedge clock);
      if (done === 1'b1) first = 1'b1;
    end
    checks++; if (!first) begin errors++; $display("FAIL tick_first_timeout got no done want done"); end
    cnt = 0; last = -1; badgap = 0;
    for (int i = 0; i < 160; i++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        cnt++;
        if (i - last != 16) badgap++;
        last = i;
      end
    end
    start = 1'b0;
    checks++; if (cnt != 10) begin errors++; $display("FAIL tick_rate got %0d dones want 10", cnt); end
    checks++; if (badgap != 0) begin errors++; $display("FAIL tick_spacing got %0d bad gaps want 0", badgap); end
    checks++; if (next_angle !== 8'd251) begin errors++; $display("FAIL tick_angle got %0d want 251", next_angle); end
    turn_left = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  task automatic test_random();
    int cx, cy, ca, dx, dy, ex, ey, ea, ox, oy, oa, qbad;
    bit r, l, f, b, ok;
    use_hash = 1'b1;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 2))
        0:       cx = int'($urandom_range(0, 4));
        1:       cx = (1 << X_W) - 1 - int'($urandom_range(0, 4));
        default: cx = int'($urandom_range(0, (1 << X_W) - 1));
      endcase
      case ($urandom_range(0, 2))
        0:       cy = int'($urandom_range(0, 4));
        1:       cy = (1 << Y_W) - 1 - int'($urandom_range(0, 4));
        default: cy = int'($urandom_range(0, (1 << Y_W) - 1));
      endcase
      case ($urandom_range(0, 9))
        0:       dx = -(1 << X_W);
        1:       dx = (1 << X_W) - 1;
        default: dx = int'($urandom_range(0, 16)) - 8;
      endcase
      dy = (n % 7 == 3) ? -(1 << Y_W) : int'($urandom_range(0, 16)) - 8;
      ca = int'($urandom_range(0, (1 << ANG_W) - 1));
      r = 1'($urandom); l = 1'($urandom); f = 1'($urandom); b = 1'($urandom);
      model(cx, cy, ca, dx, dy, r, l, f, b, ex, ey, ea);
      run_update(cx, cy, ca, dx, dy, r, l, f, b, ox, oy, oa, ok);
      checks++; if (!ok || ox != ex || oy != ey || oa != ea) begin
        errors++; $display("FAIL rand_commit[%0d] got (%0d,%0d,%0d) ok=%b want (%0d,%0d,%0d)", n, ox, oy, oa, ok, ex, ey, ea);
      end
      qbad = (qxs.size() != exp_qx.size()) ? 1 : 0;
      for (int k = 0; k < qxs.size() && qbad == 0; k++)
        if (qxs[k] != exp_qx[k] || qys[k] != exp_qy[k]) qbad = 1;
      checks++; if (qbad != 0) begin
        errors++; $display("FAIL rand_queries[%0d] got %0d queries want %0d", n, qxs.size(), exp_qx.size());
      end
    end
    use_hash = 1'b0;
  endtask

  initial begin
    test_reset();
    test_turn_wrap();
    test_move_free();
    test_slide();
    test_x_oob();
    test_reset_in_wait();
    test_tick_rate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
